vga_write_poster: RTL and testbench

- CPU-side initiator for the video RAM window; the counterpart to the video controller's external-access arbiter.
- Accepts posted CPU byte writes to 0xD000-0xEFFF (text 0xD000-0xDFFF, colour 0xE000-0xEFFF) into a small FIFO. The CPU does not stall unless the FIFO is full.
- Replays each buffered write on the video bus and holds the strobe until the controller signals ready (n_rdy low), which occurs only outside the pixel area.
- Includes an n_rdy synchroniser, a wait timeout and error/status reporting.

---
 rtl/vga_write_poster_if.sv | 31 +++
 rtl/vga_write_poster.sv | 159 +++++++++++++++
 tb/tb_vga_write_poster.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_write_poster_if.sv
// Video RAM bus between the CPU write poster (master) and the video
// controller's external-access arbiter (slave).
interface vga_write_poster_if;
  // Handshake: master holds n_we low as the request with a/d/d_oe stable;
  // slave completes it by pulling n_rdy low (asynchronous to the master clock).
  // a/d stay valid one cycle past the strobe rising edge.
  logic [15:0] a;
  logic [7:0]  d;
  logic        d_oe;
  logic        n_we;
  logic        n_oe;
  logic        n_rdy;

  modport master (
    output a,
    output d,
    output d_oe,
    output n_we,
    output n_oe,
    input  n_rdy
  );

  modport slave (
    input  a,
    input  d,
    input  d_oe,
    input  n_we,
    input  n_oe,
    output n_rdy
  );
endinterface

// File: rtl/vga_write_poster.sv
// Posts CPU byte writes to the 0xD000-0xEFFF video window into a small FIFO
// and replays them on the video bus, waiting for the controller's ready.
module vga_write_poster #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_wr,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_data,
  output logic                cpu_ack,
  output logic                full,
  output logic                busy,
  output logic                err,
  input  logic                err_clr,
  output logic [1:0]          dbg_state_o,
  vga_write_poster_if.master  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state_q;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   a_q;
  logic [7:0]    d_q;
  logic          d_oe_q;
  logic          n_we_q;
  logic [11:0]   tmo_q;
  logic          err_q, err_d;
  logic          sync1_q, sync2_q;

  logic          in_win;
  logic          rdy_s;
  logic          tmo_hit;
  logic          enq;
  logic          deq;
  logic          tmo_abort;
  logic [23:0]   head;

  assign in_win    = cpu_addr[15] & cpu_addr[14] & (cpu_addr[13] ^ cpu_addr[12]);
  assign full      = (count_q == CW'(DEPTH));
  assign cpu_ack   = cpu_wr & in_win & ~full;
  assign enq       = cpu_ack;
  assign rdy_s     = ~sync2_q;
  assign tmo_hit   = (tmo_q == 12'(TIMEOUT));
  // Ready wins over a timeout landing in the same cycle.
  assign deq       = (state_q == S_STROBE) & (rdy_s | tmo_hit);
  assign tmo_abort = (state_q == S_STROBE) & ~rdy_s & tmo_hit;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(enq) - CW'(deq);
    if (err_clr)   err_d = 1'b0;
    if (tmo_abort) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= {cpu_addr, cpu_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      sync1_q  <= bus.n_rdy;
      sync2_q  <= sync1_q;
    end
  end

  // Bus outputs are registered so a/d only move when a new head is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      d_q     <= '0;
      d_oe_q  <= 1'b0;
      n_we_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (count_q != '0) begin
            a_q     <= head[23:8];
            d_q     <= head[7:0];
            d_oe_q  <= 1'b1;
            n_we_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          n_we_q  <= 1'b0;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          tmo_q <= tmo_q + 12'd1;
          if (deq) begin
            n_we_q  <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          tmo_q <= '0;
          if (count_q != '0) begin
            a_q     <= head[23:8];
            d_q     <= head[7:0];
            state_q <= S_SETUP;
          end else begin
            d_oe_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          d_oe_q  <= 1'b0;
          n_we_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy        = (count_q != '0) | (state_q != S_IDLE);
  assign err         = err_q;
  assign dbg_state_o = state_q;

  assign bus.a    = a_q;
  assign bus.d    = d_q;
  assign bus.d_oe = d_oe_q;
  assign bus.n_we = n_we_q;
  assign bus.n_oe = 1'b1;

endmodule

// File: tb/tb_vga_write_poster.sv
// Bench for vga_write_poster: directed bus-timing scenarios plus random
// traffic, checked by a FIFO-order scoreboard of expected bus writes.
module tb_vga_write_poster;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_ack, full, busy, err;
  logic        err_clr = 1'b0;
  logic [1:0]  dbg_state;

  vga_write_poster_if bus ();

  vga_write_poster #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_ack     (cpu_ack),
    .full        (full),
    .busy        (busy),
    .err         (err),
    .err_clr     (err_clr),
    .dbg_state_o (dbg_state),
    .bus         (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic in_window(input logic [15:0] addr);
    return (addr >= 16'hD000) && (addr <= 16'hEFFF);
  endfunction

  // monitor: strobe capture, ordering, occupancy and ack model
  logic        in_stb = 1'b0;
  int          stb_len = 0;
  logic [15:0] cap_a;
  logic [7:0]  cap_d;
  logic        exp_full, exp_ack;
  logic [23:0] exp_w;

  always @(negedge clk) begin
    if (rst) begin
      in_stb = 1'b0;
    end else begin
      check("n_oe_high", bus.n_oe, 1);
      if (bus.n_we == 1'b0) begin
        check("strobe_d_oe", bus.d_oe, 1);
        if (!in_stb) begin
          in_stb  = 1'b1;
          stb_len = 0;
          cap_a   = bus.a;
          cap_d   = bus.d;
        end else begin
          check("strobe_stable", {bus.a, bus.d}, {cap_a, cap_d});
        end
        stb_len++;
      end else if (in_stb) begin
        in_stb = 1'b0;
        check("hold_d_oe", bus.d_oe, 1);
        check("hold_stable", {bus.a, bus.d}, {cap_a, cap_d});
        check("strobe_len_max", (stb_len <= TIMEOUT + 1), 1);
        check("write_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("bus_write", {cap_a, cap_d}, exp_w);
        end
      end
      exp_full = (exp_q.size() == DEPTH);
      check("full", full, exp_full);
      if (exp_q.size() != 0) check("busy_when_queued", busy, 1);
      exp_ack = cpu_wr && in_window(cpu_addr) && !exp_full;
      check("cpu_ack", cpu_ack, exp_ack);
      if (exp_ack) exp_q.push_back({cpu_addr, cpu_data});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_wr   = 1'b1;
    cpu_addr = addr;
    cpu_data = data;
    tick();
    cpu_wr   = 1'b0;
  endtask

  task automatic write_retry(input logic [15:0] addr, input logic [7:0] data, input int budget);
    int   n = 0;
    logic acked = 1'b0;
    cpu_wr   = 1'b1;
    cpu_addr = addr;
    cpu_data = data;
    while (!acked && n < budget) begin
      @(negedge clk);
      acked = cpu_ack;
      n++;
      tick();
    end
    cpu_wr = 1'b0;
    check("retry_accepted", acked, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < budget);
    check("drain_busy", busy, 0);
    check("drain_sb_empty", exp_q.size(), 0);
    tick();
  endtask

  // stimulus
  logic [15:0] bad_addr [5];
  logic [8:0]  nwe_v, doe_v, busy_v;
  int          n, lowcnt;
  logic        got;

  initial begin
    bus.n_rdy = 1'b0;
    bad_addr  = '{16'hC000, 16'hCFFF, 16'hF000, 16'h1234, 16'hFFFF};
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_a", bus.a, 16'h0000);
    check("rst_d", bus.d, 8'h00);
    check("rst_d_oe", bus.d_oe, 0);
    check("rst_n_we", bus.n_we, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    tick();

    // single write with ready already asserted
    pulse_write(16'hD123, 8'h41);
    @(negedge clk);
    check("single_idle_d_oe", bus.d_oe, 0);
    check("single_busy", busy, 1);
    @(negedge clk);
    check("single_setup_d_oe", bus.d_oe, 1);
    check("single_setup_n_we", bus.n_we, 1);
    check("single_setup_bus", {bus.a, bus.d}, 24'hD12341);
    @(negedge clk);
    check("single_strobe_n_we", bus.n_we, 0);
    @(negedge clk);
    check("single_hold_n_we", bus.n_we, 1);
    check("single_hold_d_oe", bus.d_oe, 1);
    @(negedge clk);
    check("single_end_d_oe", bus.d_oe, 0);
    check("single_end_busy", busy, 0);
    tick();

    // back-to-back burst: one write every three cycles
    pulse_write(16'hD300, 8'h01);
    pulse_write(16'hD301, 8'h02);
    pulse_write(16'hE302, 8'h03);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      nwe_v[i]  = bus.n_we;
      doe_v[i]  = bus.d_oe;
      busy_v[i] = busy;
    end
    check("burst_n_we_pattern", nwe_v, 9'b110110110);
    check("burst_d_oe_pattern", doe_v, 9'b011111111);
    check("burst_busy_pattern", busy_v, 9'b011111111);
    tick();

    // window decode boundaries
    for (int i = 0; i < 5; i++) pulse_write(bad_addr[i], 8'(i));
    repeat (4) @(negedge clk);
    check("decode_no_busy", busy, 0);
    check("decode_no_strobe", bus.n_we, 1);
    tick();
    pulse_write(16'hD000, 8'h11);
    pulse_write(16'hDFFF, 8'h22);
    pulse_write(16'hE000, 8'h33);
    pulse_write(16'hEFFF, 8'h44);
    wait_idle(40);

    // stall until full, then release
    bus.n_rdy = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) pulse_write(16'hD200 + 16'(i), 8'h10 + 8'(i));
    @(negedge clk);
    check("stall_full", full, 1);
    check("stall_n_we_low", bus.n_we, 0);
    tick();
    bus.n_rdy = 1'b0;
    wait_idle(60);
    check("stall_no_err", err, 0);

    // retrying CPU against a full queue while it drains
    bus.n_rdy = 1'b1;
    repeat (3) tick();
    fork
      for (int i = 0; i < 7; i++) write_retry(16'hE100 + 16'(i), 8'h30 + 8'(i), 60);
      begin
        repeat (10) tick();
        bus.n_rdy = 1'b0;
      end
    join
    wait_idle(60);
    check("retry_no_err", err, 0);

    // timeout: first entry dropped, second completes
    bus.n_rdy = 1'b1;
    repeat (3) tick();
    pulse_write(16'hD0F0, 8'hA5);
    pulse_write(16'hE0F1, 8'h5A);
    lowcnt = 0;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.n_we == 1'b0) lowcnt++;
      if (err) got = 1'b1;
    end
    check("timeout_err_set", got, 1);
    check("timeout_strobe_cycles", lowcnt, TIMEOUT + 1);
    tick();
    bus.n_rdy = 1'b0;
    wait_idle(60);
    check("err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", err, 0);
    tick();

    // asynchronous reset in the middle of a strobe
    bus.n_rdy = 1'b1;
    repeat (3) tick();
    pulse_write(16'hDABC, 8'h77);
    pulse_write(16'hDABD, 8'h78);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.n_we && n < 10);
    check("areset_strobe_seen", bus.n_we, 0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("areset_n_we", bus.n_we, 1);
    check("areset_d_oe", bus.d_oe, 0);
    check("areset_busy", busy, 0);
    check("areset_a", bus.a, 16'h0000);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.n_rdy = 1'b0;
    tick();
    repeat (12) @(negedge clk);
    check("areset_no_replay_busy", busy, 0);
    check("areset_no_replay_n_we", bus.n_we, 1);
    tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cpu_wr    = 1'($urandom_range(0, 1));
      cpu_addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                               : 16'(32'hD000 + $urandom_range(0, 32'h1FFF));
      cpu_data  = 8'($urandom);
      bus.n_rdy = ($urandom_range(0, 9) < 3);
      err_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    cpu_wr    = 1'b0;
    err_clr   = 1'b0;
    bus.n_rdy = 1'b0;
    wait_idle(100);
    check("final_state_idle", dbg_state, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
